// File: rtl/cus19_dm_arbiter_if.sv
// cus19_dm_arbiter_if: CPU, crypto and data-memory signal bundle for the DM arbiter
interface cus19_dm_arbiter_if #(
  parameter int AW = 11,
  parameter int DW = 19
);
  logic          cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cry_req, cry_lock, cry_we, cry_gnt, cry_rvalid;
  logic [AW-1:0] cry_addr;
  logic [DW-1:0] cry_wdata, cry_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cry_req, cry_lock, cry_we, cry_addr, cry_wdata, mem_rdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output cry_gnt, cry_rvalid, cry_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cry_req, cry_lock, cry_we, cry_addr, cry_wdata, mem_rdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  cry_gnt, cry_rvalid, cry_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cus19_dm_arbiter.sv
// cus19_dm_arbiter: shares the data memory between CPU and crypto with anti-starvation and locked bursts
module cus19_dm_arbiter #(
  parameter int AW        = 11,
  parameter int DW        = 19,
  parameter int RD_LAT    = 1,
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input logic clk,
  input logic rst_n,
  cus19_dm_arbiter_if.slave bus
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int WB = $clog2(MAX_BURST + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);
  localparam logic [WB-1:0] BMAX = WB'(MAX_BURST);
  typedef enum logic [1:0] {ARB, CRY_BURST, CPU_TURN} state_t;
  state_t state, state_nx;
  logic [WW-1:0] wait_cnt, wait_nx;
  logic [WB-1:0] burst_cnt, burst_nx, burst_inc;
  logic cry_win, cpu_gnt, cry_gnt;
  logic [RD_LAT-1:0] tag_v, tag_o;
  logic tag_cpu, tag_cry;
  always_comb begin
    cry_win = state == CRY_BURST ? bus.cry_req :
              state == CPU_TURN  ? bus.cry_req & ~bus.cpu_req :
                                   bus.cry_req & (~bus.cpu_req | wait_cnt >= WMAX);
    cry_gnt = rst_n & cry_win;
    cpu_gnt = rst_n & bus.cpu_req & ~cry_win;
    bus.cpu_gnt   = cpu_gnt;
    bus.cry_gnt   = cry_gnt;
    bus.cpu_stall = bus.cpu_req & ~cpu_gnt;
    bus.mem_en    = cpu_gnt | cry_gnt;
    bus.mem_we    = cry_gnt ? bus.cry_we : cpu_gnt & bus.cpu_we;
    bus.mem_addr  = cry_gnt ? bus.cry_addr : cpu_gnt ? bus.cpu_addr : {AW{1'b0}};
    bus.mem_wdata = cry_gnt ? bus.cry_wdata : cpu_gnt ? bus.cpu_wdata : {DW{1'b0}};
    wait_nx   = cry_gnt ? '0 : (bus.cry_req && wait_cnt != WMAX) ? wait_cnt + 1'b1 : wait_cnt;
    burst_inc = burst_cnt + 1'b1;
    state_nx  = state;
    burst_nx  = burst_cnt;
    case (state)
      ARB:
        if (cry_gnt && bus.cry_lock && MAX_BURST > 1) begin
          state_nx = CRY_BURST;
          burst_nx = WB'(1);
        end
      CRY_BURST:
        if (!bus.cry_req || !bus.cry_lock) begin
          state_nx = ARB;
          burst_nx = '0;
        end else if (burst_inc == BMAX) begin
          state_nx = CPU_TURN;
          burst_nx = '0;
        end else begin
          burst_nx = burst_inc;
        end
      default: state_nx = ARB;
    endcase
    tag_cpu = tag_v[RD_LAT-1] & ~tag_o[RD_LAT-1];
    tag_cry = tag_v[RD_LAT-1] & tag_o[RD_LAT-1];
  end
  // Read tags travel alongside the DM latency so each return lands at its issuing port in order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ARB;
      wait_cnt       <= '0;
      burst_cnt      <= '0;
      tag_v          <= '0;
      tag_o          <= '0;
      bus.cpu_rvalid <= 1'b0;
      bus.cry_rvalid <= 1'b0;
      bus.cpu_rdata  <= '0;
      bus.cry_rdata  <= '0;
    end else begin
      state          <= state_nx;
      wait_cnt       <= wait_nx;
      burst_cnt      <= burst_nx;
      tag_v          <= RD_LAT'({tag_v, bus.mem_en & ~bus.mem_we});
      tag_o          <= RD_LAT'({tag_o, cry_gnt});
      bus.cpu_rvalid <= tag_cpu;
      bus.cry_rvalid <= tag_cry;
      if (tag_cpu) bus.cpu_rdata <= bus.mem_rdata;
      if (tag_cry) bus.cry_rdata <= bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_cus19_dm_arbiter.sv
// tb_cus19_dm_arbiter: directed self-checking bench for the DM arbiter (RD_LAT=1, MAX_WAIT=4, MAX_BURST=8)
module tb_cus19_dm_arbiter;
  localparam int AW = 11;
  localparam int DW = 19;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  logic [9:0]  pat3;
  logic [16:0] pat4;
  cus19_dm_arbiter_if #(.AW(AW), .DW(DW)) bus();
  cus19_dm_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1), .MAX_WAIT(4), .MAX_BURST(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  // DM model: one-cycle read latency, data is a tagged copy of the address
  always @(posedge clk) if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= {8'hA5, bus.mem_addr};
  function automatic logic [DW-1:0] dat(input logic [AW-1:0] a);
    return {8'hA5, a};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic cr, input logic cw, input logic [AW-1:0] ca,
                       input logic yr, input logic yl, input logic yw, input logic [AW-1:0] ya);
    bus.cpu_req   = cr;
    bus.cpu_we    = cw;
    bus.cpu_addr  = ca;
    bus.cpu_wdata = 19'h1234;
    bus.cry_req   = yr;
    bus.cry_lock  = yl;
    bus.cry_we    = yw;
    bus.cry_addr  = ya;
    bus.cry_wdata = 19'h4321;
  endtask
  task automatic adv;
    @(posedge clk);
    #1;
  endtask
  initial begin
    drive(1, 0, 11'd3, 1, 0, 0, 11'd4);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_gnt", bus.cpu_gnt, 0);
    chk("rst_cry_gnt", bus.cry_gnt, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("rst_cry_rvalid", bus.cry_rvalid, 0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 0);
    chk("rst_cry_rdata", bus.cry_rdata, 0);
    adv();
    rst_n = 1'b1;
    drive(1, 0, 11'd45, 0, 0, 0, 11'd0);
    @(negedge clk);
    chk("rd45_cpu_gnt", bus.cpu_gnt, 1);
    chk("rd45_cry_gnt", bus.cry_gnt, 0);
    chk("rd45_mem_en", bus.mem_en, 1);
    chk("rd45_mem_we", bus.mem_we, 0);
    chk("rd45_mem_addr", bus.mem_addr, 45);
    adv();
    drive(0, 0, 11'd0, 0, 0, 0, 11'd0);
    @(negedge clk);
    chk("rd45_rvalid_t1", bus.cpu_rvalid, 0);
    chk("idle_mem_en", bus.mem_en, 0);
    adv();
    @(negedge clk);
    chk("rd45_rvalid_t2", bus.cpu_rvalid, 1);
    chk("rd45_rdata", bus.cpu_rdata, dat(11'd45));
    chk("rd45_cry_rvalid", bus.cry_rvalid, 0);
    adv();
    @(negedge clk);
    chk("rd45_rvalid_t3", bus.cpu_rvalid, 0);
    chk("rd45_rdata_held", bus.cpu_rdata, dat(11'd45));
    adv();
    drive(1, 1, 11'd1, 1, 0, 1, 11'd2);
    pat3 = 10'b10000_10000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("fair_cry_gnt[%0d]", i), bus.cry_gnt, pat3[i]);
      chk($sformatf("fair_cpu_gnt[%0d]", i), bus.cpu_gnt, !pat3[i]);
      chk($sformatf("fair_stall[%0d]", i), bus.cpu_stall, pat3[i]);
      adv();
    end
    bus.cry_lock = 1'b1;
    pat4 = 17'h10FF0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      chk($sformatf("burst_cry_gnt[%0d]", i), bus.cry_gnt, pat4[i]);
      chk($sformatf("burst_cpu_gnt[%0d]", i), bus.cpu_gnt, !pat4[i]);
      if (pat4[i]) chk($sformatf("burst_mem_addr[%0d]", i), bus.mem_addr, 2);
      adv();
    end
    drive(0, 0, 11'd0, 0, 0, 0, 11'd0);
    @(negedge clk);
    chk("idle_no_gnt", bus.mem_en, 0);
    adv();
    drive(1, 0, 11'd10, 0, 0, 0, 11'd0);
    @(negedge clk);
    chk("il0_cpu_gnt", bus.cpu_gnt, 1);
    adv();
    drive(0, 0, 11'd0, 1, 0, 0, 11'd20);
    @(negedge clk);
    chk("il1_cry_gnt", bus.cry_gnt, 1);
    chk("il1_mem_addr", bus.mem_addr, 20);
    chk("il1_cpu_rvalid", bus.cpu_rvalid, 0);
    adv();
    drive(1, 1, 11'd7, 0, 0, 0, 11'd0);
    @(negedge clk);
    chk("il2_mem_we", bus.mem_we, 1);
    chk("il2_cpu_rvalid", bus.cpu_rvalid, 1);
    chk("il2_cpu_rdata", bus.cpu_rdata, dat(11'd10));
    chk("il2_cry_rvalid", bus.cry_rvalid, 0);
    adv();
    drive(1, 0, 11'd30, 0, 0, 0, 11'd0);
    @(negedge clk);
    chk("il3_cpu_gnt", bus.cpu_gnt, 1);
    chk("il3_cry_rvalid", bus.cry_rvalid, 1);
    chk("il3_cry_rdata", bus.cry_rdata, dat(11'd20));
    chk("il3_cpu_rvalid", bus.cpu_rvalid, 0);
    adv();
    drive(0, 0, 11'd0, 0, 0, 0, 11'd0);
    @(negedge clk);
    chk("il4_wr_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("il4_wr_cry_rvalid", bus.cry_rvalid, 0);
    adv();
    @(negedge clk);
    chk("il5_cpu_rvalid", bus.cpu_rvalid, 1);
    chk("il5_cpu_rdata", bus.cpu_rdata, dat(11'd30));
    chk("il5_cry_rdata_held", bus.cry_rdata, dat(11'd20));
    adv();
    @(negedge clk);
    chk("il6_cpu_rvalid", bus.cpu_rvalid, 0);
    adv();
    drive(1, 0, 11'd50, 0, 0, 0, 11'd0);
    @(negedge clk);
    chk("rr_cpu_gnt", bus.cpu_gnt, 1);
    adv();
    rst_n = 1'b0;
    drive(1, 0, 11'd50, 1, 1, 0, 11'd9);
    @(negedge clk);
    chk("rr_rst_cpu_gnt", bus.cpu_gnt, 0);
    chk("rr_rst_cry_gnt", bus.cry_gnt, 0);
    chk("rr_rst_mem_en", bus.mem_en, 0);
    adv();
    rst_n = 1'b1;
    drive(0, 0, 11'd0, 0, 0, 0, 11'd0);
    @(negedge clk);
    chk("rr_cpu_rvalid_a", bus.cpu_rvalid, 0);
    adv();
    @(negedge clk);
    chk("rr_cpu_rvalid_b", bus.cpu_rvalid, 0);
    chk("rr_cpu_rdata", bus.cpu_rdata, 0);
    adv();
    drive(0, 0, 11'd0, 1, 1, 1, 11'd5);
    @(negedge clk);
    chk("rb_cry_gnt", bus.cry_gnt, 1);
    adv();
    rst_n = 1'b0;
    drive(1, 0, 11'd3, 1, 1, 1, 11'd5);
    @(negedge clk);
    chk("rb_rst_cry_gnt", bus.cry_gnt, 0);
    adv();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rb_arb_cpu_gnt", bus.cpu_gnt, 1);
    chk("rb_arb_cry_gnt", bus.cry_gnt, 0);
    adv();
    drive(0, 0, 11'd0, 0, 0, 0, 11'd0);
    adv();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
